// File: rtl/pcm_feed_pkg.sv
// Shared types and default widths for the PCM FIFO feed controller.
package pcm_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PUSH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int ADDR_W_DEF = 17;
  localparam int LEN_W_DEF  = 16;

endpackage

// File: rtl/pcm_feed_ctrl.sv
// PCM FIFO write-port sequencer: host writes take priority over a VRAM streaming engine.
// Build option PCM_FEED_LOOP_EN adds stream_loop (auto-restart of the stream).
module pcm_feed_ctrl
  import pcm_feed_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_wrdata,
  input  logic              host_write,
  input  logic              host_fifo_reset,
  input  logic              stream_start,
  input  logic [ADDR_W-1:0] stream_addr,
  input  logic [LEN_W-1:0]  stream_len,
`ifdef PCM_FEED_LOOP_EN
  input  logic              stream_loop,
`endif
  input  logic              stream_abort,
  output logic              stream_busy,
  output logic              stream_done,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rddata,
  output logic [7:0]        fifo_wrdata,
  output logic              fifo_write,
  output logic              fifo_reset,
  input  logic              fifo_full,
  input  logic              fifo_almost_empty,
  output logic              overflow,
  output logic              irq_aflow
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1'b1);

  state_e            state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [LEN_W-1:0]  cnt_r, cnt_nxt_s;
  logic [7:0]        byte_r, byte_nxt_s;
  logic              push_s, done_nxt_s;
  logic              abort_s, host_ok_s, host_ovf_s;
  logic              busy_r, done_r, req_r, fwr_r, frst_r, ovf_r, irq_r;
  logic [ADDR_W-1:0] vaddr_r;
  logic [7:0]        fdata_r;

`ifdef PCM_FEED_LOOP_EN
  logic              loop_r;
  logic [ADDR_W-1:0] base_addr_r;
  logic [LEN_W-1:0]  base_len_r;
`endif

  // A FIFO reset also kills the stream; a host write in that cycle is silently dropped.
  assign abort_s    = stream_abort | host_fifo_reset;
  assign host_ok_s  = host_write & ~host_fifo_reset & ~fifo_full;
  assign host_ovf_s = host_write & ~host_fifo_reset & fifo_full;

  // Stream engine next-state, datapath updates and stream push arbitration.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    cnt_nxt_s   = cnt_r;
    byte_nxt_s  = byte_r;
    push_s      = 1'b0;
    done_nxt_s  = 1'b0;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (stream_start) begin
            addr_nxt_s = stream_addr;
            cnt_nxt_s  = stream_len;
            if (stream_len != LEN_ZERO) begin
              state_nxt_s = ST_REQ;
            end else begin
              done_nxt_s = 1'b1;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (vram_ack) begin
            byte_nxt_s  = vram_rddata;
            state_nxt_s = ST_PUSH;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_PUSH: begin
          // The host owns the FIFO port whenever it writes, even if that write is dropped.
          if (!fifo_full && !host_write) begin
            push_s      = 1'b1;
            addr_nxt_s  = addr_r + ADDR_ONE;
            cnt_nxt_s   = cnt_r - LEN_ONE;
            state_nxt_s = (cnt_r == LEN_ONE) ? ST_DONE : ST_REQ;
          end else begin
            state_nxt_s = ST_PUSH;
          end
        end
        ST_DONE: begin
          done_nxt_s = 1'b1;
`ifdef PCM_FEED_LOOP_EN
          if (loop_r) begin
            addr_nxt_s  = base_addr_r;
            cnt_nxt_s   = base_len_r;
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_IDLE;
          end
`else
          state_nxt_s = ST_IDLE;
`endif
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= ADDR_ZERO;
      cnt_r   <= LEN_ZERO;
      byte_r  <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      req_r   <= 1'b0;
      vaddr_r <= ADDR_ZERO;
      fwr_r   <= 1'b0;
      fdata_r <= 8'h00;
      frst_r  <= 1'b0;
      ovf_r   <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      byte_r  <= byte_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= done_nxt_s;
      req_r   <= (state_nxt_s == ST_REQ);
      vaddr_r <= addr_nxt_s;
      fwr_r   <= host_ok_s | push_s;
      if (host_ok_s) begin
        fdata_r <= host_wrdata;
      end else if (push_s) begin
        fdata_r <= byte_r;
      end else begin
        fdata_r <= fdata_r;
      end
      frst_r <= host_fifo_reset;
      if (host_fifo_reset) begin
        ovf_r <= 1'b0;
      end else if (host_ovf_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
      irq_r <= fifo_almost_empty & (state_nxt_s == ST_IDLE);
    end
  end

`ifdef PCM_FEED_LOOP_EN
  // Loop mode and restart parameters are captured only when a stream is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_r      <= 1'b0;
      base_addr_r <= ADDR_ZERO;
      base_len_r  <= LEN_ZERO;
    end else if (state_r == ST_IDLE && stream_start && !abort_s) begin
      loop_r      <= stream_loop;
      base_addr_r <= stream_addr;
      base_len_r  <= stream_len;
    end else begin
      loop_r      <= loop_r;
      base_addr_r <= base_addr_r;
      base_len_r  <= base_len_r;
    end
  end
`endif

  assign stream_busy = busy_r;
  assign stream_done = done_r;
  assign vram_req    = req_r;
  assign vram_addr   = vaddr_r;
  assign fifo_write  = fwr_r;
  assign fifo_wrdata = fdata_r;
  assign fifo_reset  = frst_r;
  assign overflow    = ovf_r;
  assign irq_aflow   = irq_r;

endmodule

// File: tb/tb_pcm_feed_ctrl.sv
// Directed self-checking bench for pcm_feed_ctrl; outputs are sampled on the falling clock edge.
module tb_pcm_feed_ctrl;

  logic        clk, rst;
  logic [7:0]  host_wrdata;
  logic        host_write, host_fifo_reset;
  logic        stream_start, stream_loop, stream_abort;
  logic [16:0] stream_addr;
  logic [15:0] stream_len;
  logic        stream_busy, stream_done, vram_req;
  logic [16:0] vram_addr;
  logic        vram_ack;
  logic [7:0]  vram_rddata;
  logic [7:0]  fifo_wrdata;
  logic        fifo_write, fifo_reset, fifo_full, fifo_almost_empty;
  logic        overflow, irq_aflow;

  int n_chk  = 0;
  int n_fail = 0;

  // VRAM model: byte at address a is a[7:0] ^ 8'hA5.
  logic        resp_en = 1'b1;
  logic        resp_ack = 1'b0;
  logic        man_ack = 1'b0;
  int          ack_lat = 1;
  int          rcnt = 0;
  logic [16:0] aq[$];
  logic [7:0]  wq[$];
  int          done_cnt = 0;

  assign vram_ack    = resp_ack | man_ack;
  assign vram_rddata = vram_addr[7:0] ^ 8'hA5;

  pcm_feed_ctrl dut (
    .clk(clk), .rst(rst),
    .host_wrdata(host_wrdata), .host_write(host_write), .host_fifo_reset(host_fifo_reset),
    .stream_start(stream_start), .stream_addr(stream_addr), .stream_len(stream_len),
`ifdef PCM_FEED_LOOP_EN
    .stream_loop(stream_loop),
`endif
    .stream_abort(stream_abort), .stream_busy(stream_busy), .stream_done(stream_done),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_rddata(vram_rddata),
    .fifo_wrdata(fifo_wrdata), .fifo_write(fifo_write), .fifo_reset(fifo_reset),
    .fifo_full(fifo_full), .fifo_almost_empty(fifo_almost_empty),
    .overflow(overflow), .irq_aflow(irq_aflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Acknowledge a request after it has been seen for ack_lat falling edges.
  initial forever begin
    @(negedge clk);
    if (resp_ack) begin
      resp_ack = 1'b0;
      rcnt = 0;
    end else if (resp_en && vram_req) begin
      rcnt++;
      if (rcnt >= ack_lat) begin
        resp_ack = 1'b1;
        aq.push_back(vram_addr);
      end
    end else begin
      rcnt = 0;
    end
  end

  // FIFO write and done-pulse monitor.
  initial forever begin
    @(posedge clk);
    #1;
    if (fifo_write) wq.push_back(fifo_wrdata);
    if (stream_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wq.delete();
    aq.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int   n = 0;
    logic prev_busy = 1'b1;
    while (stream_done !== 1'b1 && n < max_cyc) begin
      prev_busy = stream_busy;
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(stream_done), 32'd1);
    chk({tag, "_busy_fall"}, {30'd0, prev_busy, stream_busy}, 32'h2);
  endtask

  task automatic chk_wq(input string tag, input logic [7:0] e[$]);
    chk({tag, "_nwr"}, wq.size(), e.size());
    for (int i = 0; i < e.size() && i < wq.size(); i++) chk({tag, "_wr"}, 32'(wq[i]), 32'(e[i]));
  endtask

  task automatic chk_aq(input string tag, input logic [16:0] e[$]);
    chk({tag, "_nrd"}, aq.size(), e.size());
    for (int i = 0; i < e.size() && i < aq.size(); i++) chk({tag, "_rd"}, 32'(aq[i]), 32'(e[i]));
  endtask

  initial begin
    logic [7:0]  eb[$];
    logic [16:0] ea[$];
    int          n;
    rst = 1'b1;
    host_wrdata = 8'h00; host_write = 1'b0; host_fifo_reset = 1'b0;
    stream_start = 1'b0; stream_loop = 1'b0; stream_abort = 1'b0;
    stream_addr = 17'h0; stream_len = 16'h0;
    fifo_full = 1'b0; fifo_almost_empty = 1'b0;

    // Reset state
    step();
    chk("rst_ctl", {25'd0, stream_busy, stream_done, vram_req, fifo_write, fifo_reset, overflow, irq_aflow}, 32'h0);
    chk("rst_addr", 32'(vram_addr), 32'h0);
    chk("rst_data", 32'(fifo_wrdata), 32'h0);
    rst = 1'b0;
    step();
    chk("idle_ctl", {25'd0, stream_busy, stream_done, vram_req, fifo_write, fifo_reset, overflow, irq_aflow}, 32'h0);
    fifo_almost_empty = 1'b1;
    step();
    chk("irq_idle", 32'(irq_aflow), 32'd1);

    // T1: address wrap, ack latency 2
    clear_logs();
    ack_lat = 2;
    stream_addr = 17'h1FFFE; stream_len = 16'd4; stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    chk("t1_busy", 32'(stream_busy), 32'd1);
    chk("t1_req", 32'(vram_req), 32'd1);
    chk("t1_addr", 32'(vram_addr), 32'h1FFFE);
    chk("t1_irq_busy", 32'(irq_aflow), 32'd0);
    wait_done("t1", 80);
    step();
    chk("t1_done_pulse", 32'(stream_done), 32'd0);
    fifo_almost_empty = 1'b0;
    eb = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    chk_wq("t1", eb);
    ea = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    chk_aq("t1", ea);
    chk("t1_ndone", done_cnt, 1);

    // T2: host writes every cycle take priority over the stream
    clear_logs();
    ack_lat = 1;
    stream_addr = 17'h00040; stream_len = 16'd3; stream_start = 1'b1;
    host_write = 1'b1; host_wrdata = 8'h10;
    for (int i = 0; i < 6; i++) begin
      step();
      stream_start = 1'b0;
      chk("t2_host_wr", {23'd0, fifo_write, fifo_wrdata}, {23'd0, 1'b1, 8'h10 + i[7:0]});
      if (i < 5) host_wrdata = 8'h11 + i[7:0];
      else host_write = 1'b0;
    end
    wait_done("t2", 60);
    eb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hE5, 8'hE4, 8'hE7};
    chk_wq("t2", eb);

    // T3: full FIFO drops host byte (overflow), stream waits; FIFO reset clears all
    step();
    clear_logs();
    fifo_full = 1'b1;
    stream_addr = 17'h00200; stream_len = 16'd2; stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    step();
    host_write = 1'b1; host_wrdata = 8'h77;
    step();
    host_write = 1'b0;
    chk("t3_no_wr", 32'(fifo_write), 32'd0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    step();
    chk("t3_held", {30'd0, fifo_write, stream_busy}, 32'h1);
    fifo_full = 1'b0;
    step();
    chk("t3_push", {23'd0, fifo_write, fifo_wrdata}, {23'd0, 1'b1, 8'hA5});
    host_fifo_reset = 1'b1; host_write = 1'b1; host_wrdata = 8'h99; fifo_full = 1'b1;
    step();
    host_fifo_reset = 1'b0; host_write = 1'b0; fifo_full = 1'b0;
    chk("t3_frst", 32'(fifo_reset), 32'd1);
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    chk("t3_abort", {29'd0, stream_busy, vram_req, fifo_write}, 32'h0);
    step();
    chk("t3_frst_pulse", {30'd0, fifo_reset, overflow}, 32'h0);
    chk("t3_ndone", done_cnt, 0);
    chk("t3_nwr", wq.size(), 1);

    // T4: abort in REQ, late ack ignored
    resp_en = 1'b0;
    step();
    clear_logs();
    stream_addr = 17'h00300; stream_len = 16'd2; stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    chk("t4_req", 32'(vram_req), 32'd1);
    stream_abort = 1'b1;
    step();
    stream_abort = 1'b0; man_ack = 1'b1;
    chk("t4_req_drop", {30'd0, vram_req, stream_busy}, 32'h0);
    step();
    man_ack = 1'b0;
    step();
    step();
    chk("t4_idle", {30'd0, vram_req, stream_busy}, 32'h0);
    chk("t4_nwr", wq.size(), 0);
    chk("t4_ndone", done_cnt, 0);

    // T5: zero length, start+abort together, start while busy
    stream_addr = 17'h00055; stream_len = 16'd0; stream_start = 1'b1;
    step();
    stream_start = 1'b0;
    chk("t5_len0", {29'd0, stream_done, vram_req, stream_busy}, 32'h4);
    stream_addr = 17'h00066; stream_len = 16'd5; stream_start = 1'b1; stream_abort = 1'b1;
    step();
    chk("t5_len0_pulse", 32'(stream_done), 32'd0);
    stream_start = 1'b0; stream_abort = 1'b0;
    chk("t5_abort_wins", {30'd0, stream_busy, vram_req}, 32'h0);
    step();
    chk("t5_abort_idle", 32'(stream_busy), 32'd0);
    stream_addr = 17'h00400; stream_len = 16'd3; stream_start = 1'b1;
    step();
    stream_addr = 17'h00123; stream_len = 16'd9;
    step();
    stream_start = 1'b0;
    chk("t5_busy_addr", 32'(vram_addr), 32'h400);
    chk("t5_busy_req", 32'(vram_req), 32'd1);
    clear_logs();
    resp_en = 1'b1;
    wait_done("t5", 60);
    eb = '{8'hA5, 8'hA4, 8'hA7};
    chk_wq("t5", eb);

`ifdef PCM_FEED_LOOP_EN
    // T6: looping stream restarts until aborted
    step();
    clear_logs();
    stream_addr = 17'h00100; stream_len = 16'd2; stream_loop = 1'b1; stream_start = 1'b1;
    step();
    stream_start = 1'b0; stream_loop = 1'b0;
    n = 0;
    while (done_cnt < 3 && n < 200) begin
      step();
      n++;
    end
    chk("t6_dones", 32'(done_cnt >= 3), 32'd1);
    chk("t6_busy", 32'(stream_busy), 32'd1);
    stream_abort = 1'b1;
    step();
    stream_abort = 1'b0;
    chk("t6_stop", 32'(stream_busy), 32'd0);
    ea = '{17'h100, 17'h101, 17'h100, 17'h101, 17'h100, 17'h101};
    for (int i = 0; i < 6 && i < aq.size(); i++) chk("t6_rd", 32'(aq[i]), 32'(ea[i]));
    chk("t6_nrd", 32'(aq.size() >= 6), 32'd1);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
